tspi_tx_burst_ctl: RTL

Parametrised successor to the single-word TSPI transmit data controller. Drives a multi-word burst from the TX data source into the serial shifter. Counts words against a programmable burst length and waits a bounded time for source data. Reports completion and source underrun to the TSPI TX top-level sequencer, between the TX source FIFO and the bit shifter.

---
 rtl/tspi_pkg.sv | 25 ++
 rtl/tspi_tx_wait_tmr.sv | 45 ++++
 rtl/tspi_tx_burst_ctl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/tspi_pkg.sv
// -----------------------------------------------------------------------------
// tspi_pkg
// Shared definitions for the TSPI transmit path: the burst controller state
// encoding, default data/length widths, and the width helper used to size the
// wait and gap counters.
// -----------------------------------------------------------------------------
package tspi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_SHIFT,
      ST_GAP,
      ST_DONE
   } tspi_tx_st_t;

   localparam int TSPI_DATA_W = 8;
   localparam int TSPI_LEN_W  = 8;

   // Width of a down-counter that holds values 0 .. n-1 (at least 1 bit).
   function automatic int tspi_cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tspi_tx_wait_tmr.sv
// -----------------------------------------------------------------------------
// tspi_tx_wait_tmr
// Loadable down-counter used for the data-wait timeout and the inter-word gap.
// While clr is high the counter holds LOAD. Each enabled cycle it counts down;
// tc pulses on the enabled cycle where the count is already zero, so the
// owner sees tc on its (LOAD+1)-th enabled cycle.
//
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-high reset (loads LOAD)
//   clr  in   synchronous reload, dominates en
//   en   in   count enable
//   tc   out  terminal-count pulse (combinational)
// -----------------------------------------------------------------------------
module tspi_tx_wait_tmr #(
   parameter int          CNT_W = 4,
   parameter int unsigned LOAD  = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOAD);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = LOAD_V;
      else if (en && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= LOAD_V;
      else     cnt_q <= cnt_d;
   end

   assign tc = en && !clr && (cnt_q == '0);

endmodule

// File: rtl/tspi_tx_burst_ctl.sv
// -----------------------------------------------------------------------------
// tspi_tx_burst_ctl
// Multi-word TSPI transmit burst controller. Requests words from the TX source,
// hands each to the bit shifter, counts completed words against a programmable
// burst length and ends the burst on length match or on a source wait timeout.
//
// Optional feature: define TSPI_TX_GAP_EN to insert GAP_CYC idle cycles between
// words (never after the last one).
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   txd_en             level enable; low aborts and idles the block
//   burst_len          words per burst (0 = unlimited), sampled on IDLE exit
//   tx_dreq/tx_valid/tx_data      source request handshake
//   shift_en/shift_data/shift_cmpt shifter handshake
//   word_cnt           words completed this burst
//   txd_cmpt/underrun  burst finished / finished by timeout short of length
// -----------------------------------------------------------------------------
module tspi_tx_burst_ctl
   import tspi_pkg::*;
#(
   parameter int DATA_W   = TSPI_DATA_W,
   parameter int LEN_W    = TSPI_LEN_W,
   parameter int WAIT_CYC = 16,
   parameter int GAP_CYC  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              txd_en,
   input  logic [LEN_W-1:0]  burst_len,
   output logic              tx_dreq,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              shift_en,
   output logic [DATA_W-1:0] shift_data,
   input  logic              shift_cmpt,
   output logic [LEN_W-1:0]  word_cnt,
   output logic              txd_cmpt,
   output logic              underrun
);

   localparam int WAIT_W = tspi_cnt_w(WAIT_CYC);

   tspi_tx_st_t       st_d, st_q;
   logic [LEN_W-1:0]  len_d, len_q;
   logic [LEN_W-1:0]  word_cnt_d, word_cnt_q;
   logic [LEN_W-1:0]  word_nxt;
   logic              tx_dreq_d, tx_dreq_q;
   logic              shift_en_d, shift_en_q;
   logic [DATA_W-1:0] shift_data_d, shift_data_q;
   logic              txd_cmpt_d, txd_cmpt_q;
   logic              underrun_d, underrun_q;
   logic              wait_tc;

   assign word_nxt = word_cnt_q + 1'b1;

   // Wait timer is armed only while in REQ; any other state reloads it, so
   // each request starts a fresh WAIT_CYC window.
   tspi_tx_wait_tmr #(
      .CNT_W (WAIT_W),
      .LOAD  (WAIT_CYC - 1)
   ) u_wait_tmr (
      .clk (clk),
      .rst (rst),
      .clr (!txd_en || (st_q != ST_REQ)),
      .en  ((st_q == ST_REQ) && !tx_valid),
      .tc  (wait_tc)
   );

`ifdef TSPI_TX_GAP_EN
   localparam int GAP_W = (GAP_CYC < 1) ? 1 : $clog2(GAP_CYC + 1);
   logic gap_tc;

   tspi_tx_wait_tmr #(
      .CNT_W (GAP_W),
      .LOAD  ((GAP_CYC > 0) ? GAP_CYC - 1 : 0)
   ) u_gap_tmr (
      .clk (clk),
      .rst (rst),
      .clr (!txd_en || (st_q != ST_GAP)),
      .en  (st_q == ST_GAP),
      .tc  (gap_tc)
   );
`endif

   always_comb begin
      st_d         = st_q;
      len_d        = len_q;
      word_cnt_d   = word_cnt_q;
      tx_dreq_d    = tx_dreq_q;
      shift_en_d   = shift_en_q;
      shift_data_d = shift_data_q;
      txd_cmpt_d   = txd_cmpt_q;
      underrun_d   = underrun_q;

      if (!txd_en) begin
         // Enable low overrides everything: abort and clear all outputs.
         st_d         = ST_IDLE;
         len_d        = '0;
         word_cnt_d   = '0;
         tx_dreq_d    = 1'b0;
         shift_en_d   = 1'b0;
         shift_data_d = '0;
         txd_cmpt_d   = 1'b0;
         underrun_d   = 1'b0;
      end else begin
         case (st_q)
            ST_IDLE: begin
               len_d      = burst_len;
               word_cnt_d = '0;
               tx_dreq_d  = 1'b1;
               st_d       = ST_REQ;
            end
            ST_REQ: begin
               // Accept takes priority over a coincident timeout.
               if (tx_valid) begin
                  shift_data_d = tx_data;
                  tx_dreq_d    = 1'b0;
                  shift_en_d   = 1'b1;
                  st_d         = ST_SHIFT;
               end else if (wait_tc) begin
                  tx_dreq_d  = 1'b0;
                  underrun_d = (len_q != '0);
                  st_d       = ST_DONE;
               end
            end
            ST_SHIFT: begin
               if (shift_cmpt) begin
                  shift_en_d = 1'b0;
                  word_cnt_d = word_nxt;
                  if ((len_q != '0) && (word_nxt == len_q)) begin
                     st_d = ST_DONE;
                  end else begin
`ifdef TSPI_TX_GAP_EN
                     if (GAP_CYC > 0) begin
                        st_d = ST_GAP;
                     end else begin
                        tx_dreq_d = 1'b1;
                        st_d      = ST_REQ;
                     end
`else
                     tx_dreq_d = 1'b1;
                     st_d      = ST_REQ;
`endif
                  end
               end
            end
`ifdef TSPI_TX_GAP_EN
            ST_GAP: begin
               if (gap_tc) begin
                  tx_dreq_d = 1'b1;
                  st_d      = ST_REQ;
               end
            end
`endif
            ST_DONE: begin
               txd_cmpt_d = 1'b1;
            end
            default: st_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q         <= ST_IDLE;
         len_q        <= '0;
         word_cnt_q   <= '0;
         tx_dreq_q    <= 1'b0;
         shift_en_q   <= 1'b0;
         shift_data_q <= '0;
         txd_cmpt_q   <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         st_q         <= st_d;
         len_q        <= len_d;
         word_cnt_q   <= word_cnt_d;
         tx_dreq_q    <= tx_dreq_d;
         shift_en_q   <= shift_en_d;
         shift_data_q <= shift_data_d;
         txd_cmpt_q   <= txd_cmpt_d;
         underrun_q   <= underrun_d;
      end
   end

   assign tx_dreq    = tx_dreq_q;
   assign shift_en   = shift_en_q;
   assign shift_data = shift_data_q;
   assign word_cnt   = word_cnt_q;
   assign txd_cmpt   = txd_cmpt_q;
   assign underrun   = underrun_q;

endmodule
